noc_output_arbiter: RTL and testbench

- Per-output-port switch allocator for the 5-port mesh router (north, south, west, east, local; index order 0..4).
- Arbitrates round-robin among input ports whose front flit targets this output.
- Wormhole-locks the output from a head flit through its tail flit.
- Gates each flit transfer on downstream space, tracked either by a credit counter or by a stop signal.

---
 rtl/noc_output_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_noc_output_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_output_arbiter.sv
// ---------------------------------------------------------------------------
// noc_output_arbiter
//
// Switch allocator for one output port of a 5-port mesh router
// (north=0, south=1, west=2, east=3, local=4). It picks one input round-robin
// among the inputs whose front flit targets this output. It holds that input
// from a head flit through the matching tail flit (wormhole lock). It only
// lets a flit move when the downstream queue has room.
//
// Build option:
//   NOC_ARB_CREDIT_EN defined   : credit-counter flow control (credit_in used,
//                                 stop_in ignored)
//   NOC_ARB_CREDIT_EN undefined : stop/go flow control (stop_in used,
//                                 credit_in ignored, credits tied to 0)
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   request    per input: front flit valid and routed here
//   req_head   per input: front flit is a head flit
//   req_tail   per input: front flit is a tail flit
//   stop_in    downstream not ready (stop/go build)
//   credit_in  downstream freed one slot (credit build)
//   grant      one-hot selected input, or 0
//   fire       selected input's flit transfers this cycle
//   locked     output held by an in-flight multi-flit packet
//   credits    current credit count (0 in the stop/go build)
// ---------------------------------------------------------------------------
module noc_output_arbiter #(
   parameter int         OutputPort     = 0,
   parameter logic [4:0] PortsEnable    = 5'b11111,
   parameter int         PortQueueDepth = 4,
   localparam int        CreditW        = $clog2(PortQueueDepth + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [4:0]         request,
   input  logic [4:0]         req_head,
   input  logic [4:0]         req_tail,
   input  logic               stop_in,
   input  logic               credit_in,
   output logic [4:0]         grant,
   output logic               fire,
   output logic               locked,
   output logic [CreditW-1:0] credits
);

   typedef enum logic {
      IDLE,
      LOCKED
   } state_e;

   state_e     state_q, state_d;
   logic [2:0] owner_q, owner_d;
   logic [2:0] rr_ptr_q, rr_ptr_d;

   logic [4:0] eligible;
   logic [4:0] owner_oh;
   logic [4:0] win_oh;
   logic [2:0] winner;
   logic       found;
   logic       space;

   // Downstream space: either a credit counter or the inverted stop signal.
   // The input that is not needed goes to an unused sink.
`ifdef NOC_ARB_CREDIT_EN
   logic [CreditW-1:0] credits_q, credits_d;
   logic               unused_stop;

   assign space       = (credits_q != '0);
   assign credits     = credits_q;
   assign unused_stop = stop_in;
`else
   logic unused_credit;

   assign space         = !stop_in;
   assign credits       = '0;
   assign unused_credit = credit_in;
`endif

   // An input may compete only if it is enabled. Its flit also must not turn
   // back out the port it came in on.
   always_comb begin
      eligible = '0;
      owner_oh = '0;
      for (int i = 0; i < 5; i++) begin
         eligible[i] = request[i] & PortsEnable[i] & (i != OutputPort);
         owner_oh[i] = (owner_q == 3'(i));
      end
   end

   // Round-robin search from rr_ptr upward, modulo 5. Only head flits can
   // open a new packet. A body or tail flit seen while idle breaks the
   // protocol and is never granted.
   always_comb begin
      found  = 1'b0;
      winner = 3'd0;
      for (int k = 0; k < 5; k++) begin
         if (!found && eligible[(int'(rr_ptr_q) + k) % 5]
                    && req_head[(int'(rr_ptr_q) + k) % 5]) begin
            found  = 1'b1;
            winner = 3'((int'(rr_ptr_q) + k) % 5);
         end
      end
      win_oh = 5'b00001 << winner;
   end

   // Next-state and output logic. While reset is high all outputs are forced
   // quiet. The registers are then reloaded on the next clock edge.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      grant    = '0;
      fire     = 1'b0;
      if (!rst) begin
         case (state_q)
            IDLE: begin
               if (found) begin
                  grant = win_oh;
                  fire  = space;
                  if (space) begin
                     rr_ptr_d = (winner == 3'd4) ? 3'd0 : winner + 3'd1;
                     if (!(|(req_tail & win_oh))) begin
                        owner_d = winner;
                        state_d = LOCKED;
                     end
                  end
               end
            end
            LOCKED: begin
               grant = owner_oh;
               fire  = (|(request & owner_oh)) & space;
               if (fire && (|(req_tail & owner_oh))) begin
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   assign locked = (state_q == LOCKED) && !rst;

   // State registers for the arbiter FSM and the round-robin pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         owner_q  <= 3'd0;
         rr_ptr_q <= 3'd0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

`ifdef NOC_ARB_CREDIT_EN
   // A transfer uses one credit and a returned slot gives one back. When both
   // happen in the same cycle they cancel. A credit that arrives while the
   // counter is already full is dropped.
   always_comb begin
      credits_d = credits_q;
      if (fire && !credit_in) begin
         credits_d = credits_q - CreditW'(1);
      end else if (credit_in && !fire
                   && (credits_q != CreditW'(PortQueueDepth))) begin
         credits_d = credits_q + CreditW'(1);
      end
   end

   // Credit counter register. It starts full, matching an empty downstream
   // queue.
   always_ff @(posedge clk) begin
      if (rst) begin
         credits_q <= CreditW'(PortQueueDepth);
      end else begin
         credits_q <= credits_d;
      end
   end
`endif

endmodule

// File: tb/tb_noc_output_arbiter.sv
// ---------------------------------------------------------------------------
// tb_noc_output_arbiter
//
// Table-driven bench for noc_output_arbiter (OutputPort=3, depth 4). Each
// table row is one clock cycle of inputs plus the outputs expected in that
// cycle. When a row is driven, its expected outputs go into a scoreboard
// queue. They are popped and compared mid-cycle.
//
// A second instance with input 1 disabled is checked by a short hand-written
// sequence. Rows that exercise one flow-control build are wrapped in
// NOC_ARB_CREDIT_EN.
// ---------------------------------------------------------------------------
module tb_noc_output_arbiter;

   typedef struct {
      logic       rst;
      logic [4:0] req;
      logic [4:0] head;
      logic [4:0] tail;
      logic       stop;
      logic       cred;
      logic [4:0] exp_grant;
      logic       exp_fire;
      logic       exp_locked;
      logic [2:0] exp_credits;
   } vec_t;

   logic       clk;
   logic       rst;
   logic [4:0] request;
   logic [4:0] req_head;
   logic [4:0] req_tail;
   logic       stop_in;
   logic       credit_in;
   logic [4:0] grant,   grant_m;
   logic       fire,    fire_m;
   logic       locked,  locked_m;
   logic [2:0] credits, credits_m;

   vec_t vectors[$];
   vec_t expect_q[$];
   int   checks = 0;
   int   errors = 0;
   int   row_id = 0;

   noc_output_arbiter #(
      .OutputPort     (3),
      .PortsEnable    (5'b11111),
      .PortQueueDepth (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .request   (request),
      .req_head  (req_head),
      .req_tail  (req_tail),
      .stop_in   (stop_in),
      .credit_in (credit_in),
      .grant     (grant),
      .fire      (fire),
      .locked    (locked),
      .credits   (credits)
   );

   noc_output_arbiter #(
      .OutputPort     (3),
      .PortsEnable    (5'b11101),
      .PortQueueDepth (4)
   ) dut_mask (
      .clk       (clk),
      .rst       (rst),
      .request   (request),
      .req_head  (req_head),
      .req_tail  (req_tail),
      .stop_in   (stop_in),
      .credit_in (credit_in),
      .grant     (grant_m),
      .fire      (fire_m),
      .locked    (locked_m),
      .credits   (credits_m)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected credit output. In the stop/go build the credit port is tied to 0.
   function automatic logic [2:0] cexp(input int v);
`ifdef NOC_ARB_CREDIT_EN
      return 3'(v);
`else
      return 3'd0;
`endif
   endfunction

   // Appends one cycle of inputs and expected outputs to the table.
   task automatic addRow(input logic r, input logic [4:0] rq, input logic [4:0] hd,
                         input logic [4:0] tl, input logic st, input logic cr,
                         input logic [4:0] eg, input logic ef, input logic el,
                         input int ec);
      vec_t v;
      v.rst = r; v.req = rq; v.head = hd; v.tail = tl; v.stop = st; v.cred = cr;
      v.exp_grant = eg; v.exp_fire = ef; v.exp_locked = el; v.exp_credits = cexp(ec);
      vectors.push_back(v);
   endtask

   // Drives one row onto the inputs and records its expected outputs.
   task automatic applyStimulus(input vec_t v);
      rst       = v.rst;
      request   = v.req;
      req_head  = v.head;
      req_tail  = v.tail;
      stop_in   = v.stop;
      credit_in = v.cred;
      expect_q.push_back(v);
   endtask

   task automatic compareBits(input string name, input int id,
                              input logic [4:0] got, input logic [4:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL row%0d %s got %b want %b", id, name, got, want);
      end
   endtask

   // Pops the oldest expected record and compares it with the live outputs.
   task automatic checkOutput(input int id);
      vec_t e;
      if (expect_q.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL row%0d scoreboard empty got none want record", id);
      end else begin
         e = expect_q.pop_front();
         compareBits("grant",   id, grant,          e.exp_grant);
         compareBits("fire",    id, {4'b0, fire},   {4'b0, e.exp_fire});
         compareBits("locked",  id, {4'b0, locked}, {4'b0, e.exp_locked});
         compareBits("credits", id, {2'b0, credits}, {2'b0, e.exp_credits});
      end
   endtask

   initial begin
      rst = 1'b1; request = '0; req_head = '0; req_tail = '0;
      stop_in = 1'b0; credit_in = 1'b0;

      //     rst req      head     tail     st cr  grant    f  l  cred
      // reset state
      addRow(0, 5'b00000, 5'b00000, 5'b00000, 0, 0, 5'b00000, 0, 0, 4);
      // two single-flit packets, round-robin from 0
      addRow(0, 5'b00101, 5'b00101, 5'b00101, 0, 1, 5'b00001, 1, 0, 4);
      addRow(0, 5'b00101, 5'b00101, 5'b00101, 0, 1, 5'b00100, 1, 0, 4);
      addRow(0, 5'b00000, 5'b00000, 5'b00000, 0, 1, 5'b00000, 0, 0, 4);
      // U-turn request ignored
      addRow(0, 5'b01000, 5'b01000, 5'b01000, 0, 1, 5'b00000, 0, 0, 4);
      // south 4-flit packet, local head arrives during body
      addRow(0, 5'b00010, 5'b00010, 5'b00000, 0, 1, 5'b00010, 1, 0, 4);
      addRow(0, 5'b10010, 5'b10000, 5'b00000, 0, 1, 5'b00010, 1, 1, 4);
      addRow(0, 5'b10010, 5'b10000, 5'b00000, 0, 1, 5'b00010, 1, 1, 4);
      addRow(0, 5'b10010, 5'b10000, 5'b00010, 0, 1, 5'b00010, 1, 1, 4);
      addRow(0, 5'b10000, 5'b10000, 5'b10000, 0, 1, 5'b10000, 1, 0, 4);
      // west locks, stalls while north waits, then tail
      addRow(0, 5'b00100, 5'b00100, 5'b00000, 0, 1, 5'b00100, 1, 0, 4);
      addRow(0, 5'b00001, 5'b00001, 5'b00001, 0, 1, 5'b00100, 0, 1, 4);
      addRow(0, 5'b00101, 5'b00001, 5'b00101, 0, 1, 5'b00100, 1, 1, 4);
      addRow(0, 5'b00001, 5'b00001, 5'b00001, 0, 1, 5'b00001, 1, 0, 4);
      // body flit seen while idle is not granted
      addRow(0, 5'b00010, 5'b00000, 5'b00000, 0, 1, 5'b00000, 0, 0, 4);
`ifndef NOC_ARB_CREDIT_EN
      // stop holds the head, then the body; reset mid-packet
      addRow(0, 5'b00010, 5'b00010, 5'b00000, 1, 0, 5'b00010, 0, 0, 0);
      addRow(0, 5'b00010, 5'b00010, 5'b00000, 0, 0, 5'b00010, 1, 0, 0);
      addRow(0, 5'b00010, 5'b00000, 5'b00000, 1, 0, 5'b00010, 0, 1, 0);
      addRow(0, 5'b00010, 5'b00000, 5'b00000, 0, 0, 5'b00010, 1, 1, 0);
      addRow(1, 5'b00010, 5'b00000, 5'b00000, 0, 0, 5'b00000, 0, 0, 0);
      addRow(0, 5'b10010, 5'b10000, 5'b10000, 0, 0, 5'b10000, 1, 0, 0);
      addRow(0, 5'b00000, 5'b00000, 5'b00000, 0, 0, 5'b00000, 0, 0, 0);
`else
      // credit exhaustion on a 6-flit west packet, then refill and saturate
      addRow(1, 5'b00000, 5'b00000, 5'b00000, 0, 0, 5'b00000, 0, 0, 4);
      addRow(0, 5'b00100, 5'b00100, 5'b00000, 0, 0, 5'b00100, 1, 0, 4);
      addRow(0, 5'b00100, 5'b00000, 5'b00000, 0, 0, 5'b00100, 1, 1, 3);
      addRow(0, 5'b00100, 5'b00000, 5'b00000, 0, 0, 5'b00100, 1, 1, 2);
      addRow(0, 5'b00100, 5'b00000, 5'b00000, 0, 0, 5'b00100, 1, 1, 1);
      addRow(0, 5'b00100, 5'b00000, 5'b00000, 0, 0, 5'b00100, 0, 1, 0);
      addRow(0, 5'b00100, 5'b00000, 5'b00000, 0, 1, 5'b00100, 0, 1, 0);
      addRow(0, 5'b00100, 5'b00000, 5'b00000, 0, 0, 5'b00100, 1, 1, 1);
      addRow(0, 5'b00100, 5'b00000, 5'b00000, 0, 1, 5'b00100, 0, 1, 0);
      addRow(0, 5'b00100, 5'b00000, 5'b00100, 0, 1, 5'b00100, 1, 1, 1);
      addRow(0, 5'b00000, 5'b00000, 5'b00000, 0, 1, 5'b00000, 0, 0, 1);
      addRow(0, 5'b00000, 5'b00000, 5'b00000, 0, 1, 5'b00000, 0, 0, 2);
      addRow(0, 5'b00000, 5'b00000, 5'b00000, 0, 1, 5'b00000, 0, 0, 3);
      addRow(0, 5'b00000, 5'b00000, 5'b00000, 0, 1, 5'b00000, 0, 0, 4);
      addRow(0, 5'b00000, 5'b00000, 5'b00000, 0, 0, 5'b00000, 0, 0, 4);
      // stop_in has no effect in the credit build
      addRow(0, 5'b00001, 5'b00001, 5'b00001, 1, 0, 5'b00001, 1, 0, 4);
      addRow(0, 5'b00000, 5'b00000, 5'b00000, 0, 0, 5'b00000, 0, 0, 3);
`endif

      repeat (2) @(posedge clk);
      foreach (vectors[i]) begin
         @(posedge clk);
         #1;
         row_id = i;
         applyStimulus(vectors[i]);
         #3;
         checkOutput(i);
      end

      // Masked instance: east is the U-turn and south is disabled.
      @(posedge clk); #1;
      rst = 1'b1; request = '0; req_head = '0; req_tail = '0;
      stop_in = 1'b0; credit_in = 1'b0;
      #3;
      compareBits("mask_rst_grant", 900, grant_m, 5'b00000);
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         rst = 1'b0; request = 5'b01010; req_head = 5'b01010; req_tail = 5'b01010;
         #3;
         compareBits("mask_grant", 901 + c, grant_m, 5'b00000);
         compareBits("mask_fire",  901 + c, {4'b0, fire_m}, 5'b00000);
      end
      @(posedge clk); #1;
      request = 5'b01110; req_head = 5'b01110; req_tail = 5'b01110;
      #3;
      compareBits("mask_west_grant", 903, grant_m, 5'b00100);
      compareBits("mask_west_fire",  903, {4'b0, fire_m}, 5'b00001);
      compareBits("mask_locked",     903, {4'b0, locked_m}, 5'b00000);
      @(posedge clk); #1;
      request = '0; req_head = '0; req_tail = '0;

      checks++;
      if (expect_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain got %0d want 0", expect_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
